// File: rtl/fpfma_pkg.sv
// Shared fpfma constants: float format defaults, special codes, rounding modes
// and result-status bit positions.
package fpfma_pkg;

    localparam int unsigned FP_WIDTH     = 32;
    localparam int unsigned FP_EXP_WIDTH = 8;
    localparam int unsigned FP_SIG_WIDTH = 23;

    localparam logic [31:0] code_NaN  = 32'h7FC0_0000;
    localparam logic [31:0] code_PINF = 32'h7F80_0000;
    localparam logic [31:0] code_NINF = 32'hFF80_0000;

    // 2'b11 also rounds to nearest-even; the datapath receives it unchanged.
    typedef enum logic [1:0] {
        RND_ZERO = 2'b00,
        RND_NEAR = 2'b01,
        RND_RNE  = 2'b10
    } rnd_mode_e;

    localparam int unsigned ST_WIDTH = 4;
    localparam int unsigned ST_NAN   = 3;
    localparam int unsigned ST_INF   = 2;
    localparam int unsigned ST_ZERO  = 1;
    localparam int unsigned ST_SUB   = 0;

endpackage

// File: rtl/fma_issue_ctrl_if.sv
// Operand/result valid-ready streams of fma_issue_ctrl.
// Carries out_status only when FMA_ISSUE_STATUS_EN is defined.
interface fma_issue_ctrl_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TAG_WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [WIDTH-1:0]     in_c;
    logic [1:0]           in_rnd;
    logic [TAG_WIDTH-1:0] in_tag;

    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_result;
    logic [TAG_WIDTH-1:0] out_tag;

`ifdef FMA_ISSUE_STATUS_EN
    logic [3:0]           out_status;

    modport master (
        output in_valid, in_a, in_b, in_c, in_rnd, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_status
    );
    modport slave (
        input  in_valid, in_a, in_b, in_c, in_rnd, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_status
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_c, in_rnd, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );
    modport slave (
        input  in_valid, in_a, in_b, in_c, in_rnd, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
`endif

endinterface

// File: rtl/fma_result_fifo.sv
// Small in-order result FIFO; wrap-bit pointers give full/empty, and a push
// into a full FIFO is taken only alongside a pop.
module fma_result_fifo #(
    parameter int unsigned DW    = 36,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wr_data,
    input  logic          pop,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic          do_push, do_pop;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        rd_data = mem_q[rd_ptr_q[AW-1:0]];

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/fma_issue_ctrl.sv
// Clocked issue/return wrapper around the combinational fpfma datapath.
// Define FMA_ISSUE_STATUS_EN to return per-result {nan, inf, zero, subnormal}.
module fma_issue_ctrl
    import fpfma_pkg::*;
#(
    parameter int unsigned WIDTH      = FP_WIDTH,
    parameter int unsigned EXP_WIDTH  = FP_EXP_WIDTH,
    parameter int unsigned SIG_WIDTH  = FP_SIG_WIDTH,
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    fma_issue_ctrl_if.slave                    io,
    output logic [WIDTH-1:0]                   fma_a,
    output logic [WIDTH-1:0]                   fma_b,
    output logic [WIDTH-1:0]                   fma_c,
    output logic [1:0]                         fma_rnd,
    input  logic [WIDTH-1:0]                   fma_result,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+2)-1:0]    inflight
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 2);
`ifdef FMA_ISSUE_STATUS_EN
    localparam int unsigned EW = ST_WIDTH + WIDTH + TAG_WIDTH;
`else
    localparam int unsigned EW = WIDTH + TAG_WIDTH;
`endif

    logic                 s1_valid_q, s1_valid_d;
    logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;
    logic [WIDTH-1:0]     fma_a_q, fma_a_d;
    logic [WIDTH-1:0]     fma_b_q, fma_b_d;
    logic [WIDTH-1:0]     fma_c_q, fma_c_d;
    logic [1:0]           fma_rnd_q, fma_rnd_d;
    logic [CW-1:0]        inflight_q, inflight_d;

    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic                 s1_advance, in_ready, accept;
    logic [EW-1:0]        fifo_wr_data, fifo_rd_data;

    always_comb begin
        fifo_pop   = ~fifo_empty & io.out_ready;
        s1_advance = s1_valid_q & (~fifo_full | fifo_pop);
        fifo_push  = s1_advance;
        in_ready   = ~s1_valid_q | s1_advance;
        accept     = io.in_valid & in_ready;

        s1_valid_d = accept | (s1_valid_q & ~s1_advance);
        s1_tag_d   = s1_tag_q;
        fma_a_d    = fma_a_q;
        fma_b_d    = fma_b_q;
        fma_c_d    = fma_c_q;
        fma_rnd_d  = fma_rnd_q;
        // Operand pins keep their last value once S1 drains.
        if (accept) begin
            s1_tag_d  = io.in_tag;
            fma_a_d   = io.in_a;
            fma_b_d   = io.in_b;
            fma_c_d   = io.in_c;
            fma_rnd_d = io.in_rnd;
        end
        inflight_d = inflight_q + CW'(accept) - CW'(fifo_pop);
    end

`ifdef FMA_ISSUE_STATUS_EN
    logic [ST_WIDTH-1:0] wr_status;
    logic                exp_ones, exp_zero, frac_zero;

    always_comb begin
        exp_ones  = &fma_result[SIG_WIDTH +: EXP_WIDTH];
        exp_zero  = ~|fma_result[SIG_WIDTH +: EXP_WIDTH];
        frac_zero = ~|fma_result[SIG_WIDTH-1:0];
        wr_status          = '0;
        wr_status[ST_NAN]  = exp_ones & ~frac_zero;
        wr_status[ST_INF]  = exp_ones & frac_zero;
        wr_status[ST_ZERO] = exp_zero & frac_zero;
        wr_status[ST_SUB]  = exp_zero & ~frac_zero;
        fifo_wr_data       = {wr_status, fma_result, s1_tag_q};
    end

    assign io.out_status = fifo_rd_data[EW-1 -: ST_WIDTH];
`else
    assign fifo_wr_data = {fma_result, s1_tag_q};
`endif

    fma_result_fifo #(
        .DW    (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (fifo_wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_tag_q   <= '0;
            fma_a_q    <= '0;
            fma_b_q    <= '0;
            fma_c_q    <= '0;
            fma_rnd_q  <= '0;
            inflight_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_tag_q   <= s1_tag_d;
            fma_a_q    <= fma_a_d;
            fma_b_q    <= fma_b_d;
            fma_c_q    <= fma_c_d;
            fma_rnd_q  <= fma_rnd_d;
            inflight_q <= inflight_d;
        end
    end

    assign io.in_ready   = in_ready;
    assign io.out_valid  = ~fifo_empty;
    assign io.out_result = fifo_rd_data[TAG_WIDTH +: WIDTH];
    assign io.out_tag    = fifo_rd_data[TAG_WIDTH-1:0];
    assign fma_a         = fma_a_q;
    assign fma_b         = fma_b_q;
    assign fma_c         = fma_c_q;
    assign fma_rnd       = fma_rnd_q;
    assign inflight      = inflight_q;
    assign busy          = (inflight_q != '0);

endmodule

// File: tb/tb_fma_issue_ctrl.sv
// Directed bench for fma_issue_ctrl with a behavioural fpfma stand-in.
// Status checks are compiled in when FMA_ISSUE_STATUS_EN is defined.
module tb_fma_issue_ctrl;
    import fpfma_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  fma_a, fma_b, fma_c, fma_result;
    logic [1:0]    fma_rnd;
    logic          busy;
    logic [1:0]    inflight;

    int errors = 0;
    int checks = 0;

    logic [31:0] op_a [8];
    logic [31:0] op_b [8];
    logic [31:0] op_c [8];
    logic [1:0]  op_rnd [8];
    logic [3:0]  op_tag [8];
    logic [31:0] got_res [8];
    logic [3:0]  got_tag [8];
    logic [3:0]  got_st [8];
    int          got_cyc [8];
    int          inf_at [64];
    bit          rdy_at [64];
    bit          acc_at [64];
    int          acc_n, rcv_n;

    fma_issue_ctrl_if #(.WIDTH(W), .TAG_WIDTH(TW)) io ();

    fma_issue_ctrl #(
        .WIDTH      (W),
        .EXP_WIDTH  (8),
        .SIG_WIDTH  (23),
        .TAG_WIDTH  (TW),
        .FIFO_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .io         (io),
        .fma_a      (fma_a),
        .fma_b      (fma_b),
        .fma_c      (fma_c),
        .fma_rnd    (fma_rnd),
        .fma_result (fma_result),
        .busy       (busy),
        .inflight   (inflight)
    );

    always #5 clk = ~clk;

    function automatic bit is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // Stand-in for the fpfma datapath: exact for the directed special cases,
    // an operand-unique token otherwise.
    function automatic logic [31:0] fpfma_model(input logic [31:0] a, b, c);
        if (is_nan(a) || is_nan(b) || is_nan(c)) return 32'h7FC0_0000;
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && c == 32'h4040_0000) return 32'h40A0_0000;
        if ((a == 32'd0 || b == 32'd0) && c == 32'd0) return 32'd0;
        return a ^ {b[15:0], b[31:16]} ^ c;
    endfunction

    always_comb fma_result = fpfma_model(fma_a, fma_b, fma_c);

    task automatic run_ops(input int n, input int stall);
        int cyc;
        acc_n = 0;
        rcv_n = 0;
        cyc   = 0;
        while ((acc_n < n || rcv_n < n) && cyc < 60) begin
            @(negedge clk);
            io.out_ready = (cyc >= stall);
            io.in_valid  = (acc_n < n);
            if (acc_n < n) begin
                io.in_a   = op_a[acc_n];
                io.in_b   = op_b[acc_n];
                io.in_c   = op_c[acc_n];
                io.in_rnd = op_rnd[acc_n];
                io.in_tag = op_tag[acc_n];
            end
            #1;
            inf_at[cyc] = int'(inflight);
            rdy_at[cyc] = io.in_ready;
            acc_at[cyc] = io.in_valid & io.in_ready;
            if (io.out_valid && io.out_ready && rcv_n < 8) begin
                got_res[rcv_n] = io.out_result;
                got_tag[rcv_n] = io.out_tag;
`ifdef FMA_ISSUE_STATUS_EN
                got_st[rcv_n]  = io.out_status;
`else
                got_st[rcv_n]  = 4'd0;
`endif
                got_cyc[rcv_n] = cyc;
                rcv_n++;
            end
            if (acc_at[cyc]) acc_n++;
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        io.in_valid = 1'b0; io.out_ready = 1'b1;
        io.in_a = '0; io.in_b = '0; io.in_c = '0; io.in_rnd = '0; io.in_tag = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", io.in_ready); end
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", io.out_valid); end
        checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL reset_inflight: got %0d expected 0", inflight); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (fma_a !== 32'd0 || fma_rnd !== 2'd0) begin errors++; $display("FAIL reset_fma: got a=%h rnd=%b expected 0", fma_a, fma_rnd); end
        checks++; if (io.out_result !== 32'd0 || io.out_tag !== 4'd0) begin errors++; $display("FAIL reset_out: got %h/%h expected 0/0", io.out_result, io.out_tag); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        io.in_valid = 1'b1; io.out_ready = 1'b1;
        io.in_a = 32'h3F80_0000; io.in_b = 32'h4000_0000; io.in_c = 32'h4040_0000;
        io.in_rnd = 2'b10; io.in_tag = 4'd5;
        #1;
        checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b expected 1", io.in_ready); end
        @(negedge clk);
        io.in_valid = 1'b0;
        #1;
        checks++; if (fma_a !== 32'h3F80_0000 || fma_b !== 32'h4000_0000 || fma_c !== 32'h4040_0000)
            begin errors++; $display("FAIL single_fma_ops: got %h %h %h expected 3f800000 40000000 40400000", fma_a, fma_b, fma_c); end
        checks++; if (fma_rnd !== 2'b10) begin errors++; $display("FAIL single_fma_rnd: got %b expected 10", fma_rnd); end
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", io.out_valid); end
        checks++; if (inflight !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL single_inflight_s1: got %0d/%b expected 1/1", inflight, busy); end
        @(negedge clk);
        #1;
        checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid: got %b expected 1", io.out_valid); end
        checks++; if (io.out_result !== 32'h40A0_0000) begin errors++; $display("FAIL single_result: got %h expected 40a00000", io.out_result); end
        checks++; if (io.out_tag !== 4'd5) begin errors++; $display("FAIL single_tag: got %0d expected 5", io.out_tag); end
        @(negedge clk);
        #1;
        checks++; if (io.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_drained: got valid=%b busy=%b expected 0/0", io.out_valid, busy); end
    endtask

    task automatic test_back_to_back();
        int drops;
        int peak;
        for (int i = 0; i < 8; i++) begin
            op_a[i]   = 32'h4000_0000 | (32'(i) << 12);
            op_b[i]   = 32'h3F80_0000 + 32'(i);
            op_c[i]   = 32'h0000_1000 * 32'(i + 1);
            op_rnd[i] = 2'(i);
            op_tag[i] = 4'(i);
        end
        run_ops(8, 0);
        checks++; if (rcv_n !== 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", rcv_n); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (got_tag[i] !== 4'(i)) begin errors++; $display("FAIL b2b_tag[%0d]: got %0d expected %0d", i, got_tag[i], i); end
            checks++; if (got_res[i] !== fpfma_model(op_a[i], op_b[i], op_c[i]))
                begin errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, got_res[i], fpfma_model(op_a[i], op_b[i], op_c[i])); end
        end
        drops = 0;
        peak  = 0;
        for (int c = 0; c < 10; c++) begin
            if (c < 8 && !rdy_at[c]) drops++;
            if (inf_at[c] > peak) peak = inf_at[c];
        end
        checks++; if (drops !== 0) begin errors++; $display("FAIL b2b_in_ready: got %0d low cycles expected 0", drops); end
        checks++; if (peak !== 2) begin errors++; $display("FAIL b2b_peak_inflight: got %0d expected 2", peak); end
        checks++; if (got_cyc[0] !== 2) begin errors++; $display("FAIL b2b_first_latency: got cycle %0d expected 2", got_cyc[0]); end
        checks++; if (got_cyc[7] - got_cyc[0] !== 7) begin errors++; $display("FAIL b2b_consecutive: got span %0d expected 7", got_cyc[7] - got_cyc[0]); end
    endtask

    task automatic test_backpressure();
        int early;
        for (int i = 0; i < 5; i++) begin
            op_a[i]   = 32'h4100_0000 + (32'(i) << 8);
            op_b[i]   = 32'h4080_0000 ^ 32'(i);
            op_c[i]   = 32'h3000_0000 + 32'(i * 3);
            op_rnd[i] = 2'b01;
            op_tag[i] = 4'(8 + i);
        end
        run_ops(5, 6);
        early = 0;
        for (int c = 0; c < 6; c++) if (acc_at[c]) early++;
        checks++; if (early !== 3) begin errors++; $display("FAIL bp_accepted: got %0d expected 3", early); end
        checks++; if (rdy_at[5] !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", rdy_at[5]); end
        checks++; if (inf_at[5] !== 3) begin errors++; $display("FAIL bp_inflight: got %0d expected 3", inf_at[5]); end
        checks++; if (rcv_n !== 5) begin errors++; $display("FAIL bp_count: got %0d expected 5", rcv_n); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (got_tag[i] !== 4'(8 + i) || got_res[i] !== fpfma_model(op_a[i], op_b[i], op_c[i]))
                begin errors++; $display("FAIL bp_order[%0d]: got tag %0d res %h expected tag %0d res %h", i, got_tag[i], got_res[i], 8 + i, fpfma_model(op_a[i], op_b[i], op_c[i])); end
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) begin
            op_a[i]   = 32'h4200_0000 + 32'(i);
            op_b[i]   = 32'h3E00_0000 + (32'(i) << 16);
            op_c[i]   = 32'h0001_0000 * 32'(i + 2);
            op_rnd[i] = 2'b10;
            op_tag[i] = 4'(1 + i);
        end
        run_ops(4, 3);
        checks++; if (inf_at[3] !== 3) begin errors++; $display("FAIL fpp_inflight_before: got %0d expected 3", inf_at[3]); end
        checks++; if (rdy_at[3] !== 1'b1 || acc_at[3] !== 1'b1) begin errors++; $display("FAIL fpp_accept: got ready=%b acc=%b expected 1/1", rdy_at[3], acc_at[3]); end
        checks++; if (got_cyc[0] !== 3) begin errors++; $display("FAIL fpp_pop_cycle: got %0d expected 3", got_cyc[0]); end
        checks++; if (inf_at[4] !== 3) begin errors++; $display("FAIL fpp_inflight_after: got %0d expected 3", inf_at[4]); end
        checks++; if (rcv_n !== 4) begin errors++; $display("FAIL fpp_count: got %0d expected 4", rcv_n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got_tag[i] !== 4'(1 + i) || got_res[i] !== fpfma_model(op_a[i], op_b[i], op_c[i]))
                begin errors++; $display("FAIL fpp_order[%0d]: got tag %0d res %h expected tag %0d", i, got_tag[i], got_res[i], 1 + i); end
        end
    endtask

    task automatic test_special();
        op_a[0] = 32'h0000_0000; op_b[0] = 32'h4000_0000; op_c[0] = 32'h0000_0000; op_rnd[0] = 2'b01; op_tag[0] = 4'd6;
        op_a[1] = 32'h7FC0_0000; op_b[1] = 32'h3F80_0000; op_c[1] = 32'h4040_0000; op_rnd[1] = 2'b11; op_tag[1] = 4'd7;
        run_ops(2, 0);
        checks++; if (rcv_n !== 2) begin errors++; $display("FAIL sp_count: got %0d expected 2", rcv_n); end
        checks++; if (got_res[0] !== 32'h0000_0000 || got_tag[0] !== 4'd6) begin errors++; $display("FAIL sp_zero: got %h/%0d expected 00000000/6", got_res[0], got_tag[0]); end
        checks++; if (got_res[1] !== code_NaN || got_tag[1] !== 4'd7) begin errors++; $display("FAIL sp_nan: got %h/%0d expected 7fc00000/7", got_res[1], got_tag[1]); end
`ifdef FMA_ISSUE_STATUS_EN
        checks++; if (got_st[0] !== 4'b0010) begin errors++; $display("FAIL sp_status_zero: got %b expected 0010", got_st[0]); end
        checks++; if (got_st[1] !== 4'b1000) begin errors++; $display("FAIL sp_status_nan: got %b expected 1000", got_st[1]); end
`endif
        #1;
        checks++; if (fma_rnd !== 2'b11 || fma_a !== 32'h7FC0_0000) begin errors++; $display("FAIL sp_fma_hold: got a=%h rnd=%b expected 7fc00000/11", fma_a, fma_rnd); end
    endtask

    task automatic test_reset_mid();
        int stale;
        io.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            io.in_valid = 1'b1;
            io.in_a = 32'h4500_0000 + 32'(i); io.in_b = 32'h3F80_0000; io.in_c = 32'd0;
            io.in_rnd = 2'b00; io.in_tag = 4'(12 + i);
        end
        @(negedge clk);
        io.in_valid = 1'b0;
        #1;
        checks++; if (inflight !== 2'd3) begin errors++; $display("FAIL rm_pre_inflight: got %0d expected 3", inflight); end
        rst = 1'b1;
        #1;
        checks++; if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin errors++; $display("FAIL rm_handshake: got valid=%b ready=%b expected 0/1", io.out_valid, io.in_ready); end
        checks++; if (inflight !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL rm_inflight: got %0d/%b expected 0/0", inflight, busy); end
        checks++; if (fma_a !== 32'd0) begin errors++; $display("FAIL rm_fma_a: got %h expected 0", fma_a); end
        @(negedge clk);
        rst = 1'b0;
        io.out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (io.out_valid) stale++;
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL rm_stale: got %0d valid cycles expected 0", stale); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_full_push_pop();
        test_special();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fma_issue_ctrl.md
Name: fma_issue_ctrl

Overview:
Sequential initiator for the combinational fpfma datapath. It accepts operand triples (A, B, C, rnd, tag) on a valid/ready stream and registers them onto the fpfma input pins. It captures the packed fpfma result one cycle later into a small output FIFO and returns results in order on a valid/ready stream. It is the clocked front/back end that lets the combinational FMA sit in a pipelined core.

Parameters:
WIDTH, 32, packed float width
EXP_WIDTH, 8, exponent field width
SIG_WIDTH, 23, stored fraction width
TAG_WIDTH, 4, opaque request tag carried alongside each operation
FIFO_DEPTH, 2, result FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand triple valid
in_ready  out  1  block can accept operands this cycle
in_a / in_b / in_c  in  WIDTH each  operands; result = A*B+C
in_rnd  in  2  rounding mode: 00 zero, 01 nearest, 10/11 nearest-even (11 passed through unchanged)
in_tag  in  TAG_WIDTH  request tag
fma_a / fma_b / fma_c  out  WIDTH each  registered operands driven to the fpfma instance
fma_rnd  out  2  registered rounding mode to the fpfma instance
fma_result  in  WIDTH  combinational fpfma result
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  WIDTH  packed result
out_tag  out  TAG_WIDTH  tag of out_result
busy  out  1  any operation in stage S1 or the FIFO
inflight  out  $clog2(FIFO_DEPTH+2)  count of accepted, unreturned operations

Behaviour:
- Stage S1 consists of the operand register (fma_a/b/c/rnd, s1_tag, s1_valid). The FIFO holds {result, tag}.
- Accept: in_valid & in_ready at edge N loads S1. fma_* update at N.
- S1 advance: s1_valid & (fifo not full | fifo pop this cycle) at edge N+1 writes {fma_result, s1_tag} into the FIFO.
- out_valid is high after edge N+1. Minimum latency is 1 cycle. Throughput is 1 op/cycle with out_ready held high.
- in_ready = ~s1_valid | s1_advance. The path is combinational from out_ready through the full/pop logic; there is no path from in_valid.
- When S1 empties, fma_* hold their last value (no zeroing). fma_result is sampled only when s1_valid.
- Output: out_valid = FIFO non-empty. out_result/out_tag = FIFO head. Pop on out_valid & out_ready.
- Simultaneous push and pop with the FIFO full is allowed. Count is unchanged and the pointers both advance.
- Pointers are log2(FIFO_DEPTH) bits with natural wrap. full/empty use an extra wrap bit.
- inflight counts +1 on accept and -1 on pop, both in the same cycle (net 0). The maximum value is FIFO_DEPTH+1. busy = inflight != 0.
- Ordering is strictly in order. No data is dropped or duplicated under any valid/ready pattern.
- Reset (async assert, sync release) clears:
  - s1_valid, FIFO pointers and inflight to 0
  - fma_a/b/c/rnd, out_result and out_tag to 0
  - in_ready to 1 and out_valid to 0
- Reset mid-operation discards all queued work. No result is emitted for operations accepted before reset.
- The upstream holds in_* stable while in_valid & ~in_ready. The block does not check this.

Optional Feature:
FMA_ISSUE_STATUS_EN.
- Defined: adds output out_status[3:0] = {is_nan, is_inf, is_zero, is_subnormal}.
  - Classified from fma_result at FIFO write and stored per entry.
  - is_nan: exp all-ones and fraction !=0.
  - is_inf: exp all-ones and fraction ==0.
  - is_zero: exp==0 and fraction==0.
  - is_subnormal: exp==0 and fraction!=0.
  - Resets to 0.
- Undefined: the port and its storage are absent. Behaviour is otherwise identical.

Decomposition:
- Package fpfma_pkg holds:
  - WIDTH/EXP_WIDTH/SIG_WIDTH defaults
  - code_NaN (0x7FC00000), code_PINF (0x7F800000), code_NINF (0xFF800000)
  - rounding-mode encodings RND_ZERO/RND_NEAR/RND_RNE
  - the status-bit index constants
- One sub-module: fma_result_fifo (parameterised width/depth, push/pop/full/empty, async reset).

Test Plan:
- Single op: A=0x3F800000, B=0x40000000, C=0x40400000, rnd=10, tag=5, out_ready=1 -> fma_* valid the next edge; out_valid 1 cycle after accept; out_result=0x40A00000, out_tag=5.
- Back-to-back 8 ops, tags 0..7, out_ready=1 -> in_ready stays 1; 8 results in tag order on consecutive cycles; inflight peaks at 2.
- Backpressure: out_ready=0 while offering 5 ops -> exactly FIFO_DEPTH+1=3 accepted, then in_ready=0, inflight=3. Raising out_ready drains in order, then the remaining 2 are accepted.
- Special operands: A=0x00000000, C=0x00000000 -> out_result 0x00000000 (with FMA_ISSUE_STATUS_EN: status 4'b0010). A=0x7FC00000 -> out_result code_NaN (status 4'b1000).
- Reset mid-stream: assert rst with 3 ops in flight -> out_valid=0, in_ready=1, inflight=0 immediately; no stale result after release.
- Simultaneous push/pop at full: FIFO full, S1 valid, out_ready=1, in_valid=1 -> one pop, one push, one accept in the same cycle; inflight unchanged.
